// File: rtl/game_flow_if.sv
// Signal bundle between the round sequencer and the hazard detectors / movers / display.
// The master side drives the hazard levels and score; the slave side is the sequencer.
interface game_flow_if #(
    parameter int LIVES_W = 2,
    parameter int SCORE_W = 9
);
    logic               start;
    logic               crash;
    logic               beans_clear;
    logic [SCORE_W-1:0] score;
    logic               run;
    logic               respawn;
    logic               new_game;
    logic [LIVES_W-1:0] lives;
    logic               over;
    logic               win;
    logic [2:0]         state;
    logic [SCORE_W-1:0] best;

    modport master (
        output start, crash, beans_clear, score,
        input  run, respawn, new_game, lives, over, win, state, best
    );

    modport slave (
        input  start, crash, beans_clear, score,
        output run, respawn, new_game, lives, over, win, state, best
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Round sequencer: start/crash/win handling, lives, freeze timer after a crash,
// grace window after each (re)spawn, and a best-score register across games.
module game_flow_ctrl #(
    parameter int LIVES       = 3,
    parameter int LIVES_W     = 2,
    parameter int DEATH_TICKS = 50000000,
    parameter int GRACE_TICKS = 1000000,
    parameter int CNT_W       = 26,
    parameter int SCORE_W     = 9
) (
    input  logic      clk,
    input  logic      rst,
    game_flow_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for first start press after reset
    // PLAY  | movers enabled, crash ignored while grace timer runs
    // DYING | movers frozen for the death animation
    // OVER  | lives exhausted, waiting for a new start press
    // WIN   | board cleared, waiting for a new start press
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0]   GRACE_LD = CNT_W'(GRACE_TICKS);
    localparam logic [CNT_W-1:0]   DEATH_LD = CNT_W'(DEATH_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(LIVES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               start_q;
    logic               respawn_q, respawn_d;
    logic               new_game_q, new_game_d;
    logic               run_q, over_q, win_q;
    logic               start_rise;
    logic               end_entry;

    assign start_rise = bus.start & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            lives_q    <= '0;
            best_q     <= '0;
            start_q    <= 1'b0;
            respawn_q  <= 1'b0;
            new_game_q <= 1'b0;
            run_q      <= 1'b0;
            over_q     <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lives_q    <= lives_d;
            best_q     <= best_d;
            start_q    <= bus.start;
            respawn_q  <= respawn_d;
            new_game_q <= new_game_d;
            run_q      <= (state_d == S_PLAY);
            over_q     <= (state_d == S_OVER);
            win_q      <= (state_d == S_WIN);
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lives_d    = lives_q;
        best_d     = best_q;
        respawn_d  = 1'b0;
        new_game_d = 1'b0;
        end_entry  = 1'b0;

        case (state_q)
            S_PLAY: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end
                // A cleared board takes priority over a same-cycle crash.
                if (bus.beans_clear) begin
                    state_d = S_WIN;
                end else if (bus.crash && (timer_q == '0)) begin
                    state_d = S_DYING;
                    timer_d = DEATH_LD;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end
            end
            S_DYING: begin
                if (timer_q == '0) begin
                    if (lives_q == '0) begin
                        state_d = S_OVER;
                    end else begin
                        state_d   = S_PLAY;
                        timer_d   = GRACE_LD;
                        respawn_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                // IDLE, OVER, WIN and the unused codes all wait for a start press.
                if (start_rise) begin
                    state_d    = S_PLAY;
                    timer_d    = GRACE_LD;
                    lives_d    = LIVES_LD;
                    respawn_d  = 1'b1;
                    new_game_d = 1'b1;
                end else if (state_q != S_OVER && state_q != S_WIN) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        end_entry = (state_d != state_q) && (state_d == S_OVER || state_d == S_WIN);
        if (end_entry && (bus.score > best_q)) begin
            best_d = bus.score;
        end
    end

    assign bus.run      = run_q;
    assign bus.respawn  = respawn_q;
    assign bus.new_game = new_game_q;
    assign bus.lives    = lives_q;
    assign bus.over     = over_q;
    assign bus.win      = win_q;
    assign bus.state    = state_q;
    assign bus.best     = best_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short timers (DEATH_TICKS=8, GRACE_TICKS=4).
module tb_game_flow_ctrl;
    typedef struct {
        logic       start;
        logic       crash;
        logic       beans;
        logic [8:0] score;
        int         st;
        int         run;
        int         lives;
        int         resp;
        int         ng;
        int         over;
        int         win;
        int         best;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[20];

    game_flow_if #(.LIVES_W(2), .SCORE_W(9)) bus ();

    game_flow_ctrl #(
        .LIVES      (3),
        .LIVES_W    (2),
        .DEATH_TICKS(8),
        .GRACE_TICKS(4),
        .CNT_W      (26),
        .SCORE_W    (9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int run, input int lives,
                           input int resp, input int ng, input int over, input int win,
                           input int best);
        chk({tag, ".state"},    int'(bus.state),    st);
        chk({tag, ".run"},      int'(bus.run),      run);
        chk({tag, ".lives"},    int'(bus.lives),    lives);
        chk({tag, ".respawn"},  int'(bus.respawn),  resp);
        chk({tag, ".new_game"}, int'(bus.new_game), ng);
        chk({tag, ".over"},     int'(bus.over),     over);
        chk({tag, ".win"},      int'(bus.win),      win);
        chk({tag, ".best"},     int'(bus.best),     best);
    endtask

    function automatic vec_t mk(input logic s, input logic c, input logic b, input int st,
                                input int run, input int lives, input int resp, input int ng);
        vec_t v;
        v.start = s;   v.crash = c;   v.beans = b;   v.score = 9'd0;
        v.st    = st;  v.run   = run; v.lives = lives;
        v.resp  = resp; v.ng   = ng;  v.over  = 0;   v.win = 0; v.best = 0;
        return v;
    endfunction

    initial begin
        int n;
        checks = 0;
        errors = 0;

        // Start press, grace-window crashes, first death and respawn.
        tbl[0] = mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1'b1, 1'b0, 1'b0, 1, 1, 3, 1, 1);
        tbl[2] = mk(1'b1, 1'b0, 1'b0, 1, 1, 3, 0, 0);
        for (int i = 3; i <= 5; i++) tbl[i] = mk(1'b1, 1'b1, 1'b0, 1, 1, 3, 0, 0);
        tbl[6] = mk(1'b1, 1'b1, 1'b0, 2, 0, 2, 0, 0);
        for (int i = 7; i <= 13; i++) tbl[i] = mk(1'b1, 1'b0, 1'b0, 2, 0, 2, 0, 0);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 1, 1, 2, 1, 0);
        for (int i = 15; i <= 18; i++) tbl[i] = mk(1'b1, 1'b1, 1'b0, 1, 1, 2, 0, 0);
        tbl[19] = mk(1'b1, 1'b1, 1'b0, 2, 0, 1, 0, 0);

        rst = 1'b1;
        bus.start = 1'b0;
        bus.crash = 1'b0;
        bus.beans_clear = 1'b0;
        bus.score = 9'd0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.start       = tbl[i].start;
            bus.crash       = tbl[i].crash;
            bus.beans_clear = tbl[i].beans;
            bus.score       = tbl[i].score;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].run, tbl[i].lives,
                    tbl[i].resp, tbl[i].ng, tbl[i].over, tbl[i].win, tbl[i].best);
        end

        // Crash held with start held: 8 dying + 5 play + 8 dying edges until OVER.
        bus.score = 9'd37;
        n = 0;
        while (bus.state != 3'd3 && n < 60) begin
            step();
            n++;
        end
        chk("over_latency", n, 21);
        chk_all("over", 3, 0, 0, 0, 0, 1, 0, 37);

        bus.crash = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("held_start.state", int'(bus.state), 3);
        bus.start = 1'b0;
        step();
        chk("start_low.state", int'(bus.state), 3);
        bus.start = 1'b1;
        step();
        chk_all("restart", 1, 1, 3, 1, 1, 0, 0, 37);

        // Past grace, crash and beans_clear together: win takes priority.
        bus.score = 9'd20;
        for (int i = 0; i < 4; i++) step();
        bus.crash = 1'b1;
        bus.beans_clear = 1'b1;
        step();
        chk_all("win_prio", 4, 0, 3, 0, 0, 0, 1, 37);

        bus.crash = 1'b0;
        bus.beans_clear = 1'b0;
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        bus.score = 9'd50;
        step();
        chk_all("win_restart", 1, 1, 3, 1, 1, 0, 0, 37);
        bus.beans_clear = 1'b1;
        step();
        chk_all("win_best", 4, 0, 3, 0, 0, 0, 1, 50);

        // Reset in the middle of DYING.
        bus.beans_clear = 1'b0;
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        bus.crash = 1'b1;
        step();
        chk_all("dying2", 2, 0, 2, 0, 0, 0, 0, 50);
        bus.crash = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        bus.start = 1'b0;
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
